if_fetch_stage: RTL and testbench
=================================

# if_fetch_stage

Instruction-fetch stage of the five-stage pipeline: owns the program counter, drives the synchronous instruction memory, and loads the IF/ID pipeline register. It consumes the taken-branch decision PCSrc3 and the branch target resolved in MEM, redirects fetch, and squashes wrong-path work. A one-entry skid buffer absorbs the memory's one-cycle read latency across hazard stalls, so no instruction is lost or duplicated.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset (word aligned)
- NOP, 32'h0000_0000, encoding loaded into IFID_Instr when squashed
- Clk  input  1  rising-edge clock
- Reset  input  1  synchronous, active-high reset
- PCSrc3  input  1  taken branch from branch decision; redirect request
- BranchTarget  input  32  target address from EX/MEM; bits [1:0] ignored (forced 0)
- Stall  input  1  hazard-unit stall; hold PC and IF/ID
- Instr_in  input  32  imem read data for address issued on previous cycle
- PC_out  output  32  imem read address this cycle (= PC register)
- IFID_Instr  output  32  IF/ID instruction
- IFID_PC4  output  32  IF/ID fetch address + 4
- IFID_Valid  output  1  IF/ID holds a real instruction
- Flush  output  1  combinational, = PCSrc3 & ~Reset; clears ID/EX and EX/MEM
- BranchCount  output  16  count of accepted redirects, wraps

## Operation
- Internal state: PC; fetch_valid and fetch_pc (address whose data is on Instr_in this cycle); skid_valid, skid_instr, skid_pc.
- Priority per edge: Reset > PCSrc3 > Stall > advance.
- Reset: PC=RESET_PC, fetch_valid=0, skid_valid=0, IFID_Instr=NOP, IFID_PC4=0, IFID_Valid=0, BranchCount=0.
- Advance (no Stall, no PCSrc3): fetch_pc<=PC, fetch_valid<=1, PC<=PC+4. IF/ID loads skid entry if skid_valid (then skid_valid<=0), else loads Instr_in/fetch_pc+4 with IFID_Valid<=fetch_valid.
- Stall (no PCSrc3): PC, IF/ID, BranchCount hold. If fetch_valid and !skid_valid: skid captures Instr_in, fetch_pc; skid_valid<=1. fetch_valid<=0 (held PC not counted as issued; reissued on release).
- Redirect (PCSrc3=1, overrides Stall): PC<={BranchTarget[31:2],2'b00}; fetch_valid<=0; skid_valid<=0; IFID_Instr<=NOP, IFID_Valid<=0; BranchCount<=BranchCount+1.
- Arithmetic: PC+4 and fetch_pc+4 modulo 2^32 (32'hFFFF_FFFC+4 = 0). BranchCount modulo 2^16.

## Timing
- imem contract: address on PC_out at cycle n, data on Instr_in at cycle n+1, always responds.
- Reset release to first IFID_Valid: 2 edges (edge 1 issues RESET_PC, edge 2 loads IF/ID).
- Redirect penalty: IFID_Valid low for 2 edges after the redirect edge; target instruction in IF/ID on 2nd edge after redirect.
- Stall release: IF/ID loads skid entry on first unstalled edge; next sequential instruction on the following edge; no bubble, no duplicate.
- Flush is combinational, same cycle as PCSrc3; deasserted during Reset.
- Reset mid-stall or mid-redirect: all state returns to reset values; skid discarded.
- PCSrc3 and Stall together: redirect taken, Stall ignored for that edge.
- Stall lasting many cycles: skid holds one entry; later Instr_in ignored.

## Test plan
- Reset, RESET_PC=0, mem[i]=i*4+1: -> IFID_Valid rises edge 2, IFID_Instr 1,5,9 on successive edges, IFID_PC4 4,8,12.
- Stall 3 cycles when IF/ID holds PC 8: -> IF/ID held 3 cycles; then instructions for 12,16 on consecutive edges, none dropped/duplicated.
- PCSrc3 pulse, BranchTarget=32'h0000_0103: -> Flush=1 that cycle, PC_out=32'h100 next cycle, IFID_Valid 0 for 2 edges, then IFID_PC4=32'h104, BranchCount=1.
- PCSrc3 and Stall simultaneous with skid_valid=1: -> redirect taken, skid entry discarded, target instruction first to reach IF/ID.
- RESET_PC=32'hFFFF_FFF8 free run: -> PC_out FFFF_FFF8, FFFF_FFFC, 0000_0000; IFID_PC4 for FFFF_FFFC equals 0.
- 65536 redirects then Reset asserted during Stall: -> BranchCount wraps to 0 at 65536; Reset clears all outputs to reset values next edge.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the synchronous imem and loads IF/ID.
// A one-entry skid buffer keeps the in-flight imem response across stalls.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        PCSrc3,
  input  logic [31:0] BranchTarget,
  input  logic        Stall,
  input  logic [31:0] Instr_in,
  output logic [31:0] PC_out,
  output logic [31:0] IFID_Instr,
  output logic [31:0] IFID_PC4,
  output logic        IFID_Valid,
  output logic        Flush,
  output logic [15:0] BranchCount
);

  logic [31:0] pc;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        skid_valid;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;

  logic [31:0] redirect_pc;
  logic [31:0] pc_plus4;
  logic [31:0] fetch_pc_plus4;
  logic [31:0] skid_pc_plus4;

  assign redirect_pc    = BranchTarget & ~32'h0000_0003;
  assign pc_plus4       = pc + 32'd4;
  assign fetch_pc_plus4 = fetch_pc + 32'd4;
  assign skid_pc_plus4  = skid_pc + 32'd4;

  assign PC_out = pc;
  assign Flush  = PCSrc3 & ~Reset;

  // PC and the record of which address the imem is answering this cycle.
  // A held PC during a stall is not counted as issued; it is reissued on release.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc          <= RESET_PC;
      fetch_valid <= 1'b0;
      fetch_pc    <= 32'h0000_0000;
    end else if (PCSrc3) begin
      pc          <= redirect_pc;
      fetch_valid <= 1'b0;
    end else if (Stall) begin
      fetch_valid <= 1'b0;
    end else begin
      pc          <= pc_plus4;
      fetch_pc    <= pc;
      fetch_valid <= 1'b1;
    end
  end

  // Skid entry: catches the one response that arrives while IF/ID is frozen.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      skid_valid <= 1'b0;
      skid_instr <= 32'h0000_0000;
      skid_pc    <= 32'h0000_0000;
    end else if (PCSrc3) begin
      skid_valid <= 1'b0;
    end else if (Stall) begin
      if (fetch_valid && !skid_valid) begin
        skid_valid <= 1'b1;
        skid_instr <= Instr_in;
        skid_pc    <= fetch_pc;
      end
    end else begin
      skid_valid <= 1'b0;
    end
  end

  // IF/ID register: the skid entry drains first so nothing is lost or duplicated.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      IFID_Instr <= NOP;
      IFID_PC4   <= 32'h0000_0000;
      IFID_Valid <= 1'b0;
    end else if (PCSrc3) begin
      IFID_Instr <= NOP;
      IFID_Valid <= 1'b0;
    end else if (!Stall) begin
      if (skid_valid) begin
        IFID_Instr <= skid_instr;
        IFID_PC4   <= skid_pc_plus4;
        IFID_Valid <= 1'b1;
      end else begin
        IFID_Instr <= Instr_in;
        IFID_PC4   <= fetch_pc_plus4;
        IFID_Valid <= fetch_valid;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      BranchCount <= 16'h0000;
    end else if (PCSrc3) begin
      BranchCount <= BranchCount + 16'd1;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios plus random traffic
// compared against a delivery-stream model of the fetch stage.
module tb_if_fetch_stage;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        PCSrc3 = 1'b0;
  logic [31:0] BranchTarget = 32'h0;
  logic        Stall = 1'b0;
  logic [31:0] Instr_in, Instr_in2;
  logic [31:0] PC_out, IFID_Instr, IFID_PC4;
  logic        IFID_Valid, Flush;
  logic [15:0] BranchCount;
  logic [31:0] PC_out2, IFID_Instr2, IFID_PC42;
  logic        IFID_Valid2, Flush2;
  logic [15:0] BranchCount2;

  int testsRun = 0;
  int failCount = 0;

  if_fetch_stage #(.RESET_PC(32'h0000_0000), .NOP(32'h0000_0000)) dut (
    .Clk(Clk), .Reset(Reset), .PCSrc3(PCSrc3), .BranchTarget(BranchTarget),
    .Stall(Stall), .Instr_in(Instr_in), .PC_out(PC_out), .IFID_Instr(IFID_Instr),
    .IFID_PC4(IFID_PC4), .IFID_Valid(IFID_Valid), .Flush(Flush),
    .BranchCount(BranchCount));

  if_fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .NOP(32'h0000_0000)) dutWrap (
    .Clk(Clk), .Reset(Reset), .PCSrc3(PCSrc3), .BranchTarget(BranchTarget),
    .Stall(Stall), .Instr_in(Instr_in2), .PC_out(PC_out2), .IFID_Instr(IFID_Instr2),
    .IFID_PC4(IFID_PC42), .IFID_Valid(IFID_Valid2), .Flush(Flush2),
    .BranchCount(BranchCount2));

  always #5 Clk = ~Clk;

  // Synchronous imem: mem[addr] = addr + 1, answered one cycle after the address.
  always @(posedge Clk) begin
    Instr_in  <= PC_out + 32'd1;
    Instr_in2 <= PC_out2 + 32'd1;
  end

  // Reference model: the fetch stage delivers a sequential address stream into IF/ID.
  // After reset or a redirect it needs two unstalled edges before the first delivery,
  // then every unstalled edge delivers the next address; stall edges change nothing.
  logic [31:0] mNext;
  int          mWarm;
  logic        mValid;
  logic [31:0] mInstr, mPC4;
  logic        mInstrKnown, mPC4Known, mReady = 1'b0;
  logic [15:0] mCount;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelStep(input logic r, input logic p, input logic s, input logic [31:0] t);
    if (r) begin
      mNext = 32'h0; mWarm = 0; mValid = 1'b0; mInstr = 32'h0; mPC4 = 32'h0;
      mInstrKnown = 1'b1; mPC4Known = 1'b1; mCount = 16'h0; mReady = 1'b1;
    end else if (p) begin
      mNext = {t[31:2], 2'b00}; mWarm = 0; mValid = 1'b0; mInstr = 32'h0;
      mInstrKnown = 1'b1; mCount = mCount + 16'd1;
    end else if (!s) begin
      if (mWarm < 2) mWarm++;
      if (mWarm == 2) begin
        mValid = 1'b1; mInstr = mNext + 32'd1; mPC4 = mNext + 32'd4;
        mInstrKnown = 1'b1; mPC4Known = 1'b1; mNext = mNext + 32'd4;
      end else begin
        mValid = 1'b0; mInstrKnown = 1'b0; mPC4Known = 1'b0;
      end
    end
  endtask

  task automatic compareModel();
    if (!mReady) return;
    checkOutput("ifid_valid", {31'b0, IFID_Valid}, {31'b0, mValid});
    checkOutput("branch_count", {16'b0, BranchCount}, {16'b0, mCount});
    checkOutput("pc_out", PC_out, mNext + ((mWarm == 0) ? 32'd0 : 32'd4));
    if (mInstrKnown) checkOutput("ifid_instr", IFID_Instr, mInstr);
    if (mPC4Known) checkOutput("ifid_pc4", IFID_PC4, mPC4);
  endtask

  // One cycle: drive at the falling edge, check Flush, then check state after the rising edge.
  task automatic applyStimulus(input logic r, input logic p, input logic s, input logic [31:0] t);
    @(negedge Clk);
    Reset = r; PCSrc3 = p; Stall = s; BranchTarget = t;
    #1 checkOutput("flush", {31'b0, Flush}, {31'b0, p & ~r});
    @(posedge Clk);
    modelStep(r, p, s, t);
    #1 compareModel();
  endtask

  initial begin
    logic [31:0] tgt;
    logic r, p, s;

    // Reset, then free run; the wrapping instance runs alongside.
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("wrap_pc_reset", PC_out2, 32'hFFFF_FFF8);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("wrap_pc_e1", PC_out2, 32'hFFFF_FFFC);
    checkOutput("first_valid_e1", {31'b0, IFID_Valid}, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("wrap_pc_e2", PC_out2, 32'h0000_0000);
    checkOutput("wrap_pc4_e2", IFID_PC42, 32'hFFFF_FFFC);
    checkOutput("first_instr_e2", IFID_Instr, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("wrap_pc4_e3", IFID_PC42, 32'h0000_0000);
    checkOutput("wrap_valid_e3", {31'b0, IFID_Valid2}, 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("instr_e4", IFID_Instr, 32'd9);
    checkOutput("pc4_e4", IFID_PC4, 32'd12);

    // Stall three cycles with instruction at 8 in IF/ID, then release.
    repeat (3) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);
      checkOutput("stall_hold_pc4", IFID_PC4, 32'd12);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("release_pc4_a", IFID_PC4, 32'd16);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("release_pc4_b", IFID_PC4, 32'd20);

    // Redirect to an unaligned target.
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_0103);
    checkOutput("redir_pc_out", PC_out, 32'h0000_0100);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("redir_pc4", IFID_PC4, 32'h0000_0104);
    checkOutput("redir_count", {16'b0, BranchCount}, 32'd1);

    // Fill the skid, then redirect and stall together.
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);
    tgt = $urandom & 32'h0000_FFFC;
    applyStimulus(1'b0, 1'b1, 1'b1, tgt);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("skid_discard_pc4", IFID_PC4, tgt + 32'd4);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(99) == 0);
      p = ($urandom_range(9) == 0);
      s = ($urandom_range(9) < 3);
      applyStimulus(r, p, s, $urandom);
    end

    // Counter wrap: 65536 redirects, then reset during a stall.
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 65536; i++)
      applyStimulus(1'b0, 1'b1, ($urandom_range(1) == 1), $urandom);
    checkOutput("count_wrap", {16'b0, BranchCount}, 32'd0);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0);
    checkOutput("reset_valid", {31'b0, IFID_Valid}, 32'h0);
    checkOutput("reset_pc", PC_out, 32'h0);
    checkOutput("reset_pc4", IFID_PC4, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("after_reset_instr", IFID_Instr, 32'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
